// File: rtl/sd_cmd_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sd_cmd_pkg : shared types and constants for the SD command-line PHY.
// Rev 1.0
// ---------------------------------------------------------------------------
package sd_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TX       = 3'd1,
    ST_WAIT_RSP = 3'd2,
    ST_RX       = 3'd3,
    ST_NRC      = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  localparam logic [1:0] RESP_NONE = 2'b00;
  localparam logic [1:0] RESP_48   = 2'b01;
  localparam logic [1:0] RESP_136  = 2'b10;

  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam int FRAME_LEN_48  = 48;
  localparam int FRAME_LEN_136 = 136;
  localparam int CNT_W         = 8;

  // Responses to these commands carry a reserved field where the index would be.
  function automatic logic resp_index_exempt(input logic [5:0] idx);
    return (idx == 6'd2) || (idx == 6'd9) || (idx == 6'd10) || (idx == 6'd41);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_cmd_phy_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sd_cmd_phy_if : host/pad-side signal bundle of the SD command-line PHY.
// Rev 1.0
// ---------------------------------------------------------------------------
interface sd_cmd_phy_if;
  logic         sd_tick;
  logic         cmd_start;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic [1:0]   resp_type;
  logic         cmd_pin_in;
  logic         cmd_pin_out;
  logic         cmd_oe;
  logic         busy;
  logic         done;
  logic [127:0] response;
  logic         timeout_err;
  logic         crc_err;
  logic         end_bit_err;
  logic         index_err;

  modport master (
    output sd_tick, cmd_start, cmd_index, cmd_arg, resp_type, cmd_pin_in,
    input  cmd_pin_out, cmd_oe, busy, done, response,
           timeout_err, crc_err, end_bit_err, index_err
  );

  modport slave (
    input  sd_tick, cmd_start, cmd_index, cmd_arg, resp_type, cmd_pin_in,
    output cmd_pin_out, cmd_oe, busy, done, response,
           timeout_err, crc_err, end_bit_err, index_err
  );
endinterface
`default_nettype wire

// File: rtl/sd_crc7.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sd_crc7 : bit-serial CRC7 (x^7 + x^3 + 1) with clear and enable.
// Rev 1.0
// ---------------------------------------------------------------------------
module sd_crc7
  import sd_cmd_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] crc_q, crc_d;
  logic       fb;

  always_comb begin
    fb    = din ^ crc_q[6];
    crc_d = crc_q;
    if (clr) begin
      crc_d = 7'h00;
    end else if (en) begin
      crc_d = {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      crc_q <= 7'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule
`default_nettype wire

// File: rtl/sd_cmd_phy.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sd_cmd_phy : serialises an SD command frame with CRC7 and captures the reply.
// Rev 1.0
// ---------------------------------------------------------------------------
module sd_cmd_phy
  import sd_cmd_pkg::*;
#(
  parameter int NCR_MAX  = 64,
  parameter int NRC_IDLE = 8
)
(
  input  logic         clock,
  input  logic         reset,
  sd_cmd_phy_if.slave  bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [39:0]        hdr_q, hdr_d;
  logic [5:0]         idx_q, idx_d;
  logic [1:0]         resp_q, resp_d;
  logic [127:0]       rx_q, rx_d;
  logic               rx_done_q, rx_done_d;
  logic               tout_pend_q, tout_pend_d;
  logic               pin_out_q, pin_out_d;
  logic               oe_q, oe_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [127:0]       response_q, response_d;
  logic               tout_q, tout_d;
  logic               crc_err_q, crc_err_d;
  logic               end_err_q, end_err_d;
  logic               idx_err_q, idx_err_d;

  logic               crc_en, crc_clr, crc_din;
  logic [6:0]         crc_out;
  logic [2:0]         tx_crc_sel;
  logic [CNT_W-1:0]   rx_last, rx_crc_top, rx_pos;

  sd_crc7 u_crc (
    .clock (clock),
    .reset (reset),
    .en    (crc_en),
    .clr   (crc_clr),
    .din   (crc_din),
    .crc   (crc_out)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hdr_d       = hdr_q;
    idx_d       = idx_q;
    resp_d      = resp_q;
    rx_d        = rx_q;
    rx_done_d   = rx_done_q;
    tout_pend_d = tout_pend_q;
    pin_out_d   = pin_out_q;
    oe_d        = oe_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    response_d  = response_q;
    tout_d      = tout_q;
    crc_err_d   = crc_err_q;
    end_err_d   = end_err_q;
    idx_err_d   = idx_err_q;
    crc_en      = 1'b0;
    crc_clr     = 1'b0;
    crc_din     = 1'b0;

    tx_crc_sel  = 3'(8'd46 - cnt_q);
    // The received CRC bits are fed through the checker too, so a clean frame leaves zero.
    rx_last     = (resp_q == RESP_136) ? 8'(FRAME_LEN_136 - 2) : 8'(FRAME_LEN_48 - 2);
    rx_crc_top  = (resp_q == RESP_136) ? 8'd127 : 8'(FRAME_LEN_48 - 2);
    rx_pos      = rx_last - cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_start) begin
          hdr_d       = {2'b01, bus.cmd_index, bus.cmd_arg};
          idx_d       = bus.cmd_index;
          resp_d      = (bus.resp_type == RESP_NONE) ? RESP_NONE :
                        (bus.resp_type == RESP_136)  ? RESP_136  : RESP_48;
          rx_d        = '0;
          rx_done_d   = 1'b0;
          tout_pend_d = 1'b0;
          response_d  = '0;
          tout_d      = 1'b0;
          crc_err_d   = 1'b0;
          end_err_d   = 1'b0;
          idx_err_d   = 1'b0;
          busy_d      = 1'b1;
          cnt_d       = '0;
          crc_clr     = 1'b1;
          state_d     = ST_TX;
        end
      end

      ST_TX: begin
        if (bus.sd_tick) begin
          oe_d = 1'b1;
          if (cnt_q < 8'd40) begin
            pin_out_d = hdr_q[39];
            hdr_d     = {hdr_q[38:0], 1'b0};
            crc_en    = 1'b1;
            crc_din   = hdr_q[39];
          end else if (cnt_q < 8'd47) begin
            pin_out_d = crc_out[tx_crc_sel];
          end else begin
            pin_out_d = 1'b1;
          end
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd47) begin
            cnt_d   = '0;
            state_d = (resp_q == RESP_NONE) ? ST_NRC : ST_WAIT_RSP;
          end
        end
      end

      ST_WAIT_RSP: begin
        if (bus.sd_tick) begin
          oe_d = 1'b0;
          if (!bus.cmd_pin_in) begin
            cnt_d   = '0;
            crc_clr = 1'b1;
            state_d = ST_RX;
          end else if (cnt_q == 8'(NCR_MAX - 1)) begin
            cnt_d       = '0;
            tout_pend_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      ST_RX: begin
        if (bus.sd_tick) begin
          rx_d    = {rx_q[126:0], bus.cmd_pin_in};
          crc_en  = (rx_pos >= 8'd1) && (rx_pos <= rx_crc_top);
          crc_din = bus.cmd_pin_in;
          cnt_d   = cnt_q + 8'd1;
          if (rx_pos == 8'd0) begin
            rx_done_d = 1'b1;
            cnt_d     = '0;
            state_d   = ST_NRC;
          end
        end
      end

      ST_NRC: begin
        if (bus.sd_tick) begin
          oe_d      = (resp_q == RESP_NONE);
          pin_out_d = 1'b1;
          cnt_d     = cnt_q + 8'd1;
          if (cnt_q == 8'(NRC_IDLE - 1)) begin
            oe_d    = 1'b0;
            cnt_d   = '0;
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        done_d    = 1'b1;
        busy_d    = 1'b0;
        tout_d    = tout_pend_q;
        crc_err_d = rx_done_q && (crc_out != 7'h00);
        end_err_d = rx_done_q && !rx_q[0];
        idx_err_d = rx_done_q && (resp_q == RESP_48) && !resp_index_exempt(idx_q) &&
                    (rx_q[45:40] != idx_q);
        if (!rx_done_q) begin
          response_d = '0;
        end else if (resp_q == RESP_136) begin
          response_d = {8'h00, rx_q[127:8]};
        end else begin
          response_d = {96'h0, rx_q[39:8]};
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hdr_q       <= '0;
      idx_q       <= '0;
      resp_q      <= RESP_NONE;
      rx_q        <= '0;
      rx_done_q   <= 1'b0;
      tout_pend_q <= 1'b0;
      pin_out_q   <= 1'b1;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      response_q  <= '0;
      tout_q      <= 1'b0;
      crc_err_q   <= 1'b0;
      end_err_q   <= 1'b0;
      idx_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hdr_q       <= hdr_d;
      idx_q       <= idx_d;
      resp_q      <= resp_d;
      rx_q        <= rx_d;
      rx_done_q   <= rx_done_d;
      tout_pend_q <= tout_pend_d;
      pin_out_q   <= pin_out_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      response_q  <= response_d;
      tout_q      <= tout_d;
      crc_err_q   <= crc_err_d;
      end_err_q   <= end_err_d;
      idx_err_q   <= idx_err_d;
    end
  end

  assign bus.cmd_pin_out = pin_out_q;
  assign bus.cmd_oe      = oe_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.response    = response_q;
  assign bus.timeout_err = tout_q;
  assign bus.crc_err     = crc_err_q;
  assign bus.end_bit_err = end_err_q;
  assign bus.index_err   = idx_err_q;

endmodule
`default_nettype wire

// File: doc/sd_cmd_phy.md
# sd_cmd_phy

Command-line transceiver between the SDHOST command register logic and the SD card CMD pin. The block takes a command index, argument and expected response type, and serialises a 48-bit command frame with CRC7 onto `cmd_pin_out`. It then releases the line, captures the 48-bit or 136-bit response from `cmd_pin_in`, and reports the response contents plus error flags. These results feed the response register (`response_outReg`) and the error-status bits of R032h.

## Interface
- `NCR_MAX`, 64: SD-clock ticks to wait for a response start bit before declaring timeout.
- `NRC_IDLE`, 8: SD-clock ticks of idle (line high) after a no-response command before `done`.
- `clock` in 1: system clock; the only clock in the block.
- `reset` in 1: asynchronous, active-low reset.
- `sd_tick` in 1: one-`clock` strobe marking an SD-clock bit period; all bit-level activity advances only when it is high.
- `cmd_start` in 1: launch request; accepted only in IDLE.
- `cmd_index` in 6: command index (R00eh[13:8]).
- `cmd_arg` in 32: command argument (R008h).
- `resp_type` in 2: 00 none, 01 48-bit (R1/R3/R6/R7), 10 136-bit (R2), 11 treated as 01.
- `cmd_pin_in` in 1: sampled CMD line.
- `cmd_pin_out` out 1: driven CMD line value.
- `cmd_oe` out 1: output enable for CMD pad.
- `busy` out 1: high from acceptance until `done`; feeds R024h command-inhibit.
- `done` out 1: one-`clock` completion pulse.
- `response` out 128: captured response.
- `timeout_err`, `crc_err`, `end_bit_err`, `index_err` out 1 each: valid with `done`, held until next `cmd_start`.

## Operation
- States: IDLE, TX, WAIT_RSP, RX, NRC, DONE.
- IDLE: `cmd_oe`=0, `cmd_pin_out`=1. On `cmd_start`, latch inputs, clear error flags, set `busy`, go to TX. `cmd_start` while `busy` is ignored.
- TX: frame = {0, 1, index[5:0], arg[31:0], crc7[6:0], 1}, sent MSB first, one bit per `sd_tick`. `cmd_oe`=1. CRC7 uses polynomial x^7+x^3+1 with initial value 0, computed over the first 40 bits.
- After the end bit: if `resp_type`=00, go to NRC; otherwise go to WAIT_RSP with `cmd_oe`=0.
- WAIT_RSP: sample on each tick. The first 0 is the start bit and moves the block to RX. After `NCR_MAX` ticks without a start bit, set `timeout_err` and go to DONE.
- RX: shift in the remaining 47 or 135 bits.
  - 48-bit response:
    - `response[31:0]` = frame[39:8]; `response[127:32]` = 0.
    - CRC7 is checked over frame[47:8].
    - `index_err` is set if frame[45:40] ≠ the latched index. Exception: no index check when `cmd_index` is 2, 9, 10 or 41, whose responses carry reserved index fields.
  - 136-bit response:
    - `response[119:0]` = frame[127:8]; `response[127:120]` = 0.
    - CRC7 is checked over frame[127:8].
    - No index check.
  - `end_bit_err` is set if the last bit is not 1.
  - After the last bit, go to NRC.
- NRC: count `NRC_IDLE` ticks with line released (response case) or driven high (no-response case), then go to DONE.
- DONE: pulse `done`, drop `busy`, return to IDLE.
- Asynchronous reset in any state: IDLE, `cmd_pin_out`=1, `cmd_oe`=0, `busy`=0, `done`=0, `response`=0, all error flags 0, counters 0.

## Timing
- The start bit drives on the first `sd_tick` after the `clock` edge that accepts `cmd_start`. The frame occupies exactly 48 ticks.
- `cmd_pin_out` and `cmd_oe` change only on `clock` edges where `sd_tick`=1. `cmd_pin_in` is sampled only on those edges.
- No-response latency: 48 + `NRC_IDLE` ticks, then `done` one `clock` later.
- A start bit sampled on the same tick as the `NCR_MAX`-th wait tick counts as a valid start, not a timeout.
- `response` and the error flags update on the edge that raises `done` and hold until the next acceptance.
- With `sd_tick` held low, the block holds state indefinitely.

## Structure
- Package `sd_cmd_pkg`:
  - state enum;
  - `RESP_NONE`/`RESP_48`/`RESP_136` constants;
  - CRC7 polynomial 7'h09;
  - frame lengths 48/136.
- Sub-module `sd_crc7`: serial CRC7 with enable, clear and data-bit inputs, and a 7-bit output. Instantiated once; shared by TX and RX.

## Test plan
- CMD0, arg 0, `resp_type`=00 → `cmd_pin_out` shows 48'h40_0000_0000_95; `done` after 56 ticks; all errors 0.
- CMD8, arg 32'h1AA, `resp_type`=01; card returns 48'h08_0000_01AA_13 → transmitted frame 48'h48_0000_01AA_87; `response`=32'h0000_01AA; no errors.
- CMD2, `resp_type`=10; card returns 136-bit CID with valid CRC → `response[119:0]` = CID[127:8]; `response[127:120]`=0; no errors.
- CMD8 with the line held high → `timeout_err`=1 after 64 wait ticks; `done` pulses; `response`=0.
- CMD8 response with a corrupted CRC bit, then one with index 6'h09 → `crc_err`=1 in the first case, `index_err`=1 in the second.
- `reset` asserted during bit 20 of TX → immediate IDLE, `cmd_oe`=0, `busy`=0; a new CMD0 after release sends a correct frame.
